// File: rtl/drop_pkg.sv
// Shared definitions for the drop actuator and anything that decodes its state readout.
package drop_pkg;

  localparam int DROP_TIME_W = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    OPEN  = 3'd2,
    CLOSE = 3'd3,
    COOL  = 3'd4
  } drop_state_t;

endpackage

// File: rtl/tick_prescaler.sv
// Divides the clock into time-unit ticks and counts them; shared by the OPEN and COOL timing.
module tick_prescaler #(
  parameter int TICK_DIV = 1000,
  parameter int COUNT_W  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               enable,
  output logic               tick,
  output logic [COUNT_W-1:0] tick_count
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0] presc;

  assign tick = enable && (presc == PW'(TICK_DIV - 1));

  // clear takes priority so a phase always starts from a whole time unit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc      <= '0;
      tick_count <= '0;
    end else if (clear) begin
      presc      <= '0;
      tick_count <= '0;
    end else if (enable) begin
      if (tick) begin
        presc      <= '0;
        tick_count <= tick_count + COUNT_W'(1);
      end else begin
        presc <= presc + PW'(1);
      end
    end
  end

endmodule

// File: rtl/drop_actuator.sv
// Hatch drop responder: debounces the drop request, holds the hatch open for the
// latched duration, then enforces a cooldown; reports done/aborted and counts drops.
module drop_actuator
  import drop_pkg::*;
#(
  parameter int ARM_CYCLES     = 4,
  parameter int TICK_DIV       = 1000,
  parameter int COOLDOWN_TICKS = 8,
  parameter int CNT_W          = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   drop_req,
  input  logic [DROP_TIME_W-1:0] drop_time,
  input  logic                   abort,
  output logic                   hatch_open,
  output logic                   busy,
  output logic                   done,
  output logic                   aborted,
  output logic [CNT_W-1:0]       drop_count,
  output logic [2:0]             state_dbg
);

  localparam int AW = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;

  drop_state_t            state;
  logic [AW-1:0]          arm_cnt;
  logic [DROP_TIME_W-1:0] latched;
  logic                   rearm;
  logic                   tick;
  logic [DROP_TIME_W-1:0] tick_count;
  logic                   timing_phase;
  logic                   presc_clear;

  assign hatch_open = (state == OPEN);
  assign busy       = (state != IDLE);
  assign state_dbg  = state;

  // Abort out of OPEN lands straight in COOL, so the prescaler must restart on that edge too
  assign timing_phase = (state == OPEN) || (state == COOL);
  assign presc_clear  = !timing_phase || ((state == OPEN) && abort);

  tick_prescaler #(
    .TICK_DIV (TICK_DIV),
    .COUNT_W  (DROP_TIME_W)
  ) u_prescaler (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (presc_clear),
    .enable     (timing_phase),
    .tick       (tick),
    .tick_count (tick_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      arm_cnt    <= '0;
      latched    <= '0;
      rearm      <= 1'b1;
      done       <= 1'b0;
      aborted    <= 1'b0;
      drop_count <= '0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      if (!drop_req) rearm <= 1'b1;

      case (state)
        IDLE: begin
          if (drop_req && rearm) begin
            state   <= ARM;
            arm_cnt <= '0;
            rearm   <= 1'b0;
          end
        end

        ARM: begin
          if (abort) begin
            state   <= COOL;
            aborted <= 1'b1;
          end else if (!drop_req) begin
            state <= IDLE;
          end else if (arm_cnt == AW'(ARM_CYCLES - 1)) begin
            latched <= drop_time;
            if (drop_time == '0) begin
              state   <= COOL;
              aborted <= 1'b1;
            end else begin
              state <= OPEN;
            end
          end else begin
            arm_cnt <= arm_cnt + AW'(1);
          end
        end

        // abort beats the final tick when both land on the same cycle
        OPEN: begin
          if (abort) begin
            state   <= COOL;
            aborted <= 1'b1;
          end else if (tick && (tick_count == latched - DROP_TIME_W'(1))) begin
            state <= CLOSE;
            done  <= 1'b1;
            if (drop_count != '1) drop_count <= drop_count + CNT_W'(1);
          end
        end

        CLOSE: state <= COOL;

        COOL: begin
          if (tick && (tick_count == DROP_TIME_W'(COOLDOWN_TICKS - 1))) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_drop_actuator.sv
// Randomized scoreboard bench for drop_actuator: stimulus predicts each done/aborted
// event from the timing rules, a negedge monitor pops and compares as events appear.
module tb_drop_actuator;

  localparam int TD   = 4;
  localparam int AC   = 4;
  localparam int CT   = 2;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk;
  logic          rst_n;
  logic          drop_req;
  logic [15:0]   drop_time;
  logic          abort;
  logic          hatch_open;
  logic          busy;
  logic          done;
  logic          aborted;
  logic [CW-1:0] drop_count;
  logic [2:0]    state_dbg;

  typedef struct {
    bit is_done;
    int ev_cyc;
    int open_cyc;
    int count;
    int idle_cyc;
  } exp_t;

  exp_t sb[$];
  int   n_checks    = 0;
  int   n_pass      = 0;
  int   cyc         = 0;
  int   model_count = 0;
  int   ev_seen     = 0;
  int   hatch_total = 0;

  drop_actuator #(
    .ARM_CYCLES     (AC),
    .TICK_DIV       (TD),
    .COOLDOWN_TICKS (CT),
    .CNT_W          (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .drop_req   (drop_req),
    .drop_time  (drop_time),
    .abort      (abort),
    .hatch_open (hatch_open),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted),
    .drop_count (drop_count),
    .state_dbg  (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
  endtask

  // Monitor: hatch-open run length since the last event, event pop/compare, cooldown end
  int   open_run     = 0;
  bit   pending_cool = 0;
  int   pend_idle    = 0;
  bit   prev_busy    = 0;
  exp_t e_mon;

  always @(negedge clk) begin
    if (!rst_n) begin
      open_run     = 0;
      pending_cool = 0;
      prev_busy    = 0;
    end else begin
      if (hatch_open) begin
        open_run++;
        hatch_total++;
      end
      if (done && aborted) checkOutput("done_and_aborted", 1, 0);
      if (done || aborted) begin
        ev_seen++;
        if (sb.size() == 0) begin
          checkOutput("unexpected_event", cyc, -1);
        end else begin
          e_mon = sb.pop_front();
          checkOutput("event_kind_done", int'(done), int'(e_mon.is_done));
          checkOutput("event_cycle", cyc, e_mon.ev_cyc);
          checkOutput("open_cycles", open_run, e_mon.open_cyc);
          checkOutput("event_drop_count", int'(drop_count), e_mon.count);
          pend_idle    = e_mon.idle_cyc;
          pending_cool = 1;
        end
        open_run = 0;
      end
      if (prev_busy && !busy && pending_cool) begin
        checkOutput("idle_cycle", cyc, pend_idle);
        pending_cool = 0;
      end
      prev_busy = busy;
    end
  end

  // Reference prediction from the timing rules: ARM lasts AC cycles, OPEN lasts t*TD,
  // CLOSE one cycle, COOL CT*TD cycles; abort in ARM/OPEN cuts straight to COOL.
  function automatic exp_t predict(input int c0, input int t, input int ac);
    exp_t e;
    int   open_end;
    open_end = c0 + AC + t * TD;
    if (ac > 0 && (ac <= c0 + AC || (t > 0 && ac <= open_end))) begin
      e.is_done  = 0;
      e.ev_cyc   = ac + 1;
      e.open_cyc = (ac > c0 + AC) ? ac - c0 - AC : 0;
      e.idle_cyc = e.ev_cyc + CT * TD;
    end else if (t == 0) begin
      e.is_done  = 0;
      e.ev_cyc   = c0 + AC + 1;
      e.open_cyc = 0;
      e.idle_cyc = e.ev_cyc + CT * TD;
    end else begin
      e.is_done  = 1;
      e.ev_cyc   = open_end + 1;
      e.open_cyc = t * TD;
      if (model_count < CMAX) model_count++;
      e.idle_cyc = e.ev_cyc + 1 + CT * TD;
    end
    e.count = model_count;
    return e;
  endfunction

  // One full request: falling then rising drop_req, optional abort at c0+abort_rel,
  // drop_time scrambled once latched, then held high for extra_hold idle cycles.
  task automatic applyStimulus(input int t, input int abort_rel, input int extra_hold);
    int c0;
    int ac;
    bit idle_seen;
    @(negedge clk);
    drop_req = 1'b0;
    abort    = 1'b0;
    @(negedge clk);
    drop_req  = 1'b1;
    drop_time = 16'(t);
    c0        = cyc;
    ac        = (abort_rel > 0) ? c0 + abort_rel : -1;
    sb.push_back(predict(c0, t, ac));
    idle_seen = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      abort = (ac > 0 && cyc == ac);
      if (cyc > c0 + AC) drop_time = 16'($urandom);
      if (cyc > c0 + 1 && !busy) begin
        idle_seen = 1;
        break;
      end
    end
    abort = 1'b0;
    if (!idle_seen) checkOutput("idle_timeout", int'(busy), 0);
    repeat (extra_hold) @(negedge clk);
  endtask

  int base_ev;
  int base_hatch;
  int c0s;

  initial begin
    rst_n     = 1'b0;
    drop_req  = 1'b0;
    drop_time = 16'd0;
    abort     = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_hatch_open", int'(hatch_open), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done", int'(done), 0);
    checkOutput("reset_aborted", int'(aborted), 0);
    checkOutput("reset_drop_count", int'(drop_count), 0);
    checkOutput("reset_state", int'(state_dbg), 0);
    rst_n = 1'b1;

    applyStimulus(3, 0, 0);
    checkOutput("normal_count", int'(drop_count), 1);

    // request withdrawn during ARM: back to IDLE with no event and no hatch
    base_ev    = ev_seen;
    base_hatch = hatch_total;
    @(negedge clk);
    drop_req = 1'b0;
    @(negedge clk);
    drop_req  = 1'b1;
    drop_time = 16'd3;
    c0s       = cyc;
    @(negedge clk);
    checkOutput("short_arm_state", int'(state_dbg), 1);
    @(negedge clk);
    @(negedge clk);
    drop_req = 1'b0;
    @(negedge clk);
    checkOutput("short_idle_state", int'(state_dbg), 0);
    checkOutput("short_cycle", cyc - c0s, 4);
    repeat (3) @(negedge clk);
    checkOutput("short_no_event", ev_seen - base_ev, 0);
    checkOutput("short_no_hatch", hatch_total - base_hatch, 0);
    checkOutput("short_count", int'(drop_count), model_count);

    // request held high long after completion never retriggers
    base_ev = ev_seen;
    applyStimulus(2, 0, 20);
    checkOutput("held_busy", int'(busy), 0);
    checkOutput("held_single_event", ev_seen - base_ev, 1);
    applyStimulus(1, 0, 0);

    applyStimulus(3, 9, 0);
    applyStimulus(3, 16, 0);
    applyStimulus(3, 2, 0);
    applyStimulus(0, 0, 0);

    for (int i = 0; i < 12; i++) begin
      int t;
      int mode;
      t    = $urandom_range(0, 4);
      mode = $urandom_range(0, 2);
      applyStimulus(t, (mode == 1) ? $urandom_range(1, AC + t * TD) : 0, $urandom_range(0, 3));
    end

    // asynchronous reset mid-OPEN
    @(negedge clk);
    drop_req = 1'b0;
    @(negedge clk);
    drop_req  = 1'b1;
    drop_time = 16'd3;
    c0s       = cyc;
    while (cyc < c0s + 8) @(negedge clk);
    checkOutput("pre_reset_hatch", int'(hatch_open), 1);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("async_reset_hatch", int'(hatch_open), 0);
    checkOutput("async_reset_busy", int'(busy), 0);
    checkOutput("async_reset_count", int'(drop_count), 0);
    model_count = 0;
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(3, 0, 0);
    checkOutput("post_reset_count", int'(drop_count), 1);

    // saturating drop counter
    for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0);
    checkOutput("saturated_count", int'(drop_count), CMAX);

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/drop_actuator.md
Name: drop_actuator

Overview:
- Responder on the far end of the drop request line. It takes the level request raised by the drop-decision logic (drop_activated) and the computed drop duration (t_act), and runs a timed, debounced hatch open/close sequence.
- It reports completion and abort, and keeps a count of completed drops.
- It sits between the drop-decision path and the hatch motor driver.

Parameters:
- ARM_CYCLES, 4: consecutive cycles drop_req must stay high before the hatch opens (min 1).
- TICK_DIV, 1000: clock cycles per time unit of drop_time (min 1).
- COOLDOWN_TICKS, 8: time units of lockout after each drop or abort (min 1).
- CNT_W, 8: width of drop_count.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- drop_req  in  1  level request, driven from drop_activated.
- drop_time  in  16  hatch open duration in time units, driven from t_act.
- abort  in  1  synchronous emergency close request.
- hatch_open  out  1  hatch motor open command.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse when a drop completes normally.
- aborted  out  1  one-cycle pulse when a sequence is rejected or aborted.
- drop_count  out  CNT_W  number of completed drops, saturating.
- state_dbg  out  3  current state encoding.

Behaviour:
- Reset (rst_n=0, async): state IDLE; all outputs 0; arm counter, prescaler, tick counter and drop_count cleared; rearm flag set. Reset mid-sequence drops hatch_open immediately.
- Moore outputs, decoded from the registered state. hatch_open = (state==OPEN). busy = (state!=IDLE).
- Rearm flag:
  - Set in any cycle drop_req=0 is sampled.
  - Cleared on IDLE->ARM.
  - A new drop therefore needs drop_req to fall and rise again; a request held high never retriggers.
- IDLE: drop_req=1 and rearm=1 -> ARM, arm counter=0.
- ARM:
  - drop_req=0 -> IDLE, no pulse.
  - drop_req=1 with arm counter==ARM_CYCLES-1: drop_time sampled that cycle is latched.
    - Latched value 0 -> COOL with aborted pulse.
    - Otherwise -> OPEN, prescaler and tick counter cleared.
  - Net effect: ARM lasts exactly ARM_CYCLES cycles.
- OPEN:
  - Prescaler counts 0..TICK_DIV-1 and wraps.
  - Tick counter increments on each wrap.
  - Wrap with tick counter==latched-1 -> CLOSE.
  - hatch_open is therefore high for exactly latched*TICK_DIV cycles.
  - drop_time and drop_req changes are ignored.
- CLOSE: one cycle. done=1; drop_count += 1, saturating at 2^CNT_W-1. Then -> COOL.
- COOL: prescaler/tick counter cleared on entry. Lasts COOLDOWN_TICKS*TICK_DIV cycles, then -> IDLE. All requests ignored.
- abort: sampled only in ARM and OPEN.
  - Goes directly to COOL with aborted=1 for that cycle's registered transition. No done, no count.
  - Abort coinciding with the final OPEN tick: abort wins.
  - Ignored in IDLE, CLOSE and COOL.
- done and aborted are registered. Both appear in the cycle the state enters CLOSE or COOL respectively, and are never high together.
- Tick counter is 16 bits. It never wraps, because the latched duration is at most 65535.

Decomposition:
- Shared package drop_pkg:
  - State encoding: IDLE=0, ARM=1, OPEN=2, CLOSE=3, COOL=4 (3 bits).
  - Constant DROP_TIME_W=16.
  - Reused by the display/decision path for the state_dbg readout.
- One sub-module, tick_prescaler:
  - Ports: clear, enable, tick out, tick count out.
  - Instantiated once and shared by the OPEN and COOL timing.
- FSM, rearm flag, latch and counter stay in drop_actuator.

Test Plan (TICK_DIV=4, ARM_CYCLES=4, COOLDOWN_TICKS=2, drop_req rises sampled at cycle 0):
- Normal drop, drop_time=3 -> ARM cycles 1–4; hatch_open cycles 5–16 (12 cycles); done at 17; busy until 25; IDLE at 26; drop_count=1.
- drop_req high only cycles 0–2 -> ARM entered then IDLE at cycle 4; hatch_open never 1; no done, no aborted; drop_count unchanged.
- drop_req held high through the whole sequence and 20 cycles beyond -> exactly one drop. A second drop occurs only after drop_req goes 0 for ≥1 cycle and returns to 1.
- abort=1 at cycle 9 during drop_time=3 -> hatch_open low from cycle 10; aborted pulse at 10; COOL cycles 10–17; no done; drop_count unchanged. Also check abort on the final OPEN tick (cycle 16): aborted and no done.
- drop_time=0 at cycle 4 -> no hatch_open; aborted at 5; COOL 8 cycles. Also check drop_count saturation with CNT_W=2: after 5 drops, count reads 3.
- rst_n low at cycle 8 mid-OPEN -> hatch_open, busy and drop_count read 0 asynchronously. After release, a fresh drop_req rise gives a normal sequence.
